// File: rtl/sr_latch_driver_pkg.sv
// Shared types and defaults for the SR latch bank write driver.
package sr_latch_driver_pkg;

   localparam int DEF_WIDTH         = 4;
   localparam int DEF_PULSE_CYCLES  = 2;
   localparam int DEF_SETTLE_CYCLES = 2;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      PULSE,
      RELEASE,
      SETTLE,
      CHECK
   } state_e;

   function automatic int maxOf(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchronizer bringing the asynchronous latch outputs into the
// clock domain; both stages clear on reset.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] sync_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/sr_latch_driver.sv
// Writes a target value into a bank of gated SR latches with a
// setup / gate pulse / hold / settle sequence, then reads it back.
module sr_latch_driver
   import sr_latch_driver_pkg::*;
#(
   parameter int WIDTH         = DEF_WIDTH,
   parameter int PULSE_CYCLES  = DEF_PULSE_CYCLES,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] r,
   output logic             latch_gate,
   input  logic [WIDTH-1:0] q_in,
   output logic [WIDTH-1:0] rd_data,
   output logic             done,
   output logic             err
);

   localparam int CNT_W = $clog2(maxOf(PULSE_CYCLES, SETTLE_CYCLES)) + 1;
   localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   state_e           state_q;
   logic [WIDTH-1:0] set_q;
   logic [WIDTH-1:0] rst_q;
   logic             gate_q;
   logic             done_q;
   logic             err_q;
   logic [WIDTH-1:0] rdData_q;
   logic [WIDTH-1:0] target_q;
   logic [CNT_W-1:0] cnt_q;

   logic [WIDTH-1:0] qSync;
   logic [WIDTH-1:0] setVec_d;
   logic [WIDTH-1:0] rstVec_d;

   sync_2ff #(.WIDTH(WIDTH)) u_sync (
      .clock   (clock),
      .reset   (reset),
      .async_i (q_in),
      .sync_o  (qSync)
   );

   // Only bits that differ from the current latch state get a command, so
   // set and reset are disjoint by construction.
   always_comb begin
      setVec_d = wr_data & ~qSync;
      rstVec_d = ~wr_data & qSync;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         set_q    <= '0;
         rst_q    <= '0;
         gate_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         rdData_q <= '0;
         target_q <= '0;
         cnt_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (wr_valid) begin
                  target_q <= wr_data;
                  err_q    <= 1'b0;
                  if ((setVec_d | rstVec_d) != '0) begin
                     set_q   <= setVec_d;
                     rst_q   <= rstVec_d;
                     state_q <= SETUP;
                  end else begin
                     state_q <= CHECK;
                  end
               end
            end
            SETUP: begin
               gate_q  <= 1'b1;
               cnt_q   <= PULSE_LOAD;
               state_q <= PULSE;
            end
            PULSE: begin
               if (cnt_q == '0) begin
                  gate_q  <= 1'b0;
                  state_q <= RELEASE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            // s/r stay on through the cycle after the gate falls for hold time.
            RELEASE: begin
               set_q   <= '0;
               rst_q   <= '0;
               cnt_q   <= SETTLE_LOAD;
               state_q <= SETTLE;
            end
            SETTLE: begin
               if (cnt_q == '0) begin
                  state_q <= CHECK;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            CHECK: begin
               rdData_q <= qSync;
               done_q   <= 1'b1;
               err_q    <= (qSync != target_q);
               state_q  <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign wr_ready   = (state_q == IDLE);
   assign s          = set_q;
   assign r          = rst_q;
   assign latch_gate = gate_q;
   assign done       = done_q;
   assign err        = err_q;
   assign rd_data    = rdData_q;

   setResetDisjoint: assert property (@(posedge clock) disable iff (reset) ((s & r) == '0));

endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench for sr_latch_driver: a behavioural SR latch bank
// feeds q_in, and a write-level model predicts commands, timing and readback.
module tb_sr_latch_driver;

   localparam int W = 4;
   localparam int P = 2;
   localparam int S = 2;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         wr_valid = 1'b0;
   logic         wr_ready;
   logic [W-1:0] wr_data = '0;
   logic [W-1:0] s;
   logic [W-1:0] r;
   logic         latch_gate;
   logic [W-1:0] q_in;
   logic [W-1:0] rd_data;
   logic         done;
   logic         err;

   logic [W-1:0] latchVal   = '0;
   logic [W-1:0] stuckMask  = '0;
   logic [W-1:0] modelLatch = '0;

   int errors = 0;
   int checks = 0;

   logic [W-1:0] obsS0, obsR0, obsRd;
   int           obsGate, obsOverlap, obsLat;
   logic         obsActivity, obsErr;

   sr_latch_driver #(.WIDTH(W), .PULSE_CYCLES(P), .SETTLE_CYCLES(S)) dut (
      .clock      (clock),
      .reset      (reset),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_data    (wr_data),
      .s          (s),
      .r          (r),
      .latch_gate (latch_gate),
      .q_in       (q_in),
      .rd_data    (rd_data),
      .done       (done),
      .err        (err)
   );

   always #5 clock = ~clock;

   // Transparent SR latch bank: while the gate is high, set bits go to 1 and
   // reset bits go to 0; stuck bits always read back as 0.
   always @(latch_gate or s or r) begin
      if (latch_gate === 1'b1) latchVal = (latchVal | s) & ~r;
   end
   assign q_in = latchVal & ~stuckMask;

   // Predicts one write from the current latch content and updates it.
   task automatic modelWrite(input logic [W-1:0] d, output logic [W-1:0] eS, output logic [W-1:0] eR,
                             output int eLat, output int eGate, output logic [W-1:0] eRd, output logic eErr);
      logic [W-1:0] vis;
      vis = modelLatch & ~stuckMask;
      eS = d & ~vis;
      eR = ~d & vis;
      if ((eS | eR) != '0) begin
         eLat  = 3 + P + S;
         eGate = P;
      end else begin
         eLat  = 1;
         eGate = 0;
      end
      modelLatch = (modelLatch | eS) & ~eR;
      eRd  = modelLatch & ~stuckMask;
      eErr = (eRd != d);
   endtask

   // Issues one write and records what the DUT does until done.
   task automatic applyStimulus(input logic [W-1:0] d);
      obsS0 = '0; obsR0 = '0; obsRd = '0; obsErr = 1'b0;
      obsGate = 0; obsOverlap = 0; obsLat = -1; obsActivity = 1'b0;
      @(negedge clock);
      wr_valid = 1'b1;
      wr_data  = d;
      for (int k = 0; k < 50 && !wr_ready; k++) @(negedge clock);
      if (!wr_ready) begin
         checks++; errors++;
         $display("[TB] FAIL accept_timeout: wr_ready=%b required 1", wr_ready);
         wr_valid = 1'b0;
         return;
      end
      @(posedge clock);
      @(negedge clock);
      wr_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (i > 0) @(negedge clock);
         if (i == 0) begin
            obsS0 = s;
            obsR0 = r;
         end
         if (latch_gate) obsGate++;
         if ((s & r) != '0) obsOverlap++;
         if ((s | r) != '0 || latch_gate) obsActivity = 1'b1;
         if (done) begin
            obsLat = i;
            obsRd  = rd_data;
            obsErr = err;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", wr_ready); end
      checks++; if (s !== '0) begin errors++; $display("[TB] FAIL reset_s: got %b expected 0000", s); end
      checks++; if (r !== '0) begin errors++; $display("[TB] FAIL reset_r: got %b expected 0000", r); end
      checks++; if (latch_gate !== 1'b0) begin errors++; $display("[TB] FAIL reset_gate: got %b expected 0", latch_gate); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
      checks++; if (rd_data !== '0) begin errors++; $display("[TB] FAIL reset_rd: got %b expected 0000", rd_data); end
      reset = 1'b0;
      @(negedge clock);
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready: got %b expected 1", wr_ready); end
   endtask

   task automatic test_write(input string name, input logic [W-1:0] d);
      logic [W-1:0] eS, eR, eRd;
      int eLat, eGate;
      logic eErr;
      modelWrite(d, eS, eR, eLat, eGate, eRd, eErr);
      applyStimulus(d);
      checks++; if (obsLat !== eLat) begin errors++; $display("[TB] FAIL %s_latency: got %0d expected %0d", name, obsLat, eLat); end
      checks++; if (obsRd !== eRd) begin errors++; $display("[TB] FAIL %s_rd: got %b expected %b", name, obsRd, eRd); end
      checks++; if (obsErr !== eErr) begin errors++; $display("[TB] FAIL %s_err: got %b expected %b", name, obsErr, eErr); end
      checks++; if (obsGate !== eGate) begin errors++; $display("[TB] FAIL %s_gate_cycles: got %0d expected %0d", name, obsGate, eGate); end
      checks++; if (obsOverlap !== 0) begin errors++; $display("[TB] FAIL %s_s_and_r: got %0d overlapping cycles expected 0", name, obsOverlap); end
      if (eLat != 1) begin
         checks++; if (obsS0 !== eS) begin errors++; $display("[TB] FAIL %s_setup_s: got %b expected %b", name, obsS0, eS); end
         checks++; if (obsR0 !== eR) begin errors++; $display("[TB] FAIL %s_setup_r: got %b expected %b", name, obsR0, eR); end
      end else begin
         checks++; if (obsActivity !== 1'b0) begin errors++; $display("[TB] FAIL %s_quiet: got activity %b expected 0", name, obsActivity); end
      end
   endtask

   task automatic test_stuck_bit();
      stuckMask = 4'b0001;
      test_write("stuck_write", 4'b0001);
      test_write("stuck_clear", 4'b0000);
      stuckMask = '0;
      repeat (3) @(negedge clock);
   endtask

   task automatic test_reset_mid_pulse();
      logic [W-1:0] d, eS, eR;
      int doneSeen;
      d  = ~modelLatch;
      eS = d & ~modelLatch;
      eR = ~d & modelLatch;
      modelLatch = (modelLatch | eS) & ~eR;
      @(negedge clock);
      wr_valid = 1'b1;
      wr_data  = d;
      @(posedge clock);
      @(negedge clock);
      wr_valid = 1'b0;
      @(negedge clock);
      checks++; if (latch_gate !== 1'b1) begin errors++; $display("[TB] FAIL mid_gate_before: got %b expected 1", latch_gate); end
      reset = 1'b1;
      #1;
      checks++; if (latch_gate !== 1'b0) begin errors++; $display("[TB] FAIL mid_gate_drop: got %b expected 0", latch_gate); end
      checks++; if (s !== '0) begin errors++; $display("[TB] FAIL mid_s_drop: got %b expected 0000", s); end
      checks++; if (r !== '0) begin errors++; $display("[TB] FAIL mid_r_drop: got %b expected 0000", r); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL mid_done: got %b expected 0", done); end
      @(negedge clock);
      reset = 1'b0;
      doneSeen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (done) doneSeen++;
      end
      checks++; if (doneSeen !== 0) begin errors++; $display("[TB] FAIL mid_no_done: got %0d pulses expected 0", doneSeen); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready: got %b expected 1", wr_ready); end
      test_write("after_reset", 4'b1111);
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a, b, eS, eR, eRdA, eRdB;
      int eLatA, eLatB, eGate, readyIdx, nDone;
      int doneIdx[2];
      logic [W-1:0] doneRd[2];
      logic eErr, armed;
      a = ~modelLatch;
      b = a ^ 4'b0101;
      modelWrite(a, eS, eR, eLatA, eGate, eRdA, eErr);
      modelWrite(b, eS, eR, eLatB, eGate, eRdB, eErr);
      doneIdx[0] = -1; doneIdx[1] = -1;
      doneRd[0] = '0; doneRd[1] = '0;
      @(negedge clock);
      wr_valid = 1'b1;
      wr_data  = a;
      @(posedge clock);
      #1 wr_data = b;
      armed = 1'b0;
      readyIdx = -1;
      nDone = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clock);
         if (armed && wr_valid) wr_valid = 1'b0;
         if (done && nDone < 2) begin
            doneIdx[nDone] = i;
            doneRd[nDone]  = rd_data;
            nDone++;
         end
         if (wr_ready && !armed) begin
            readyIdx = i;
            armed = 1'b1;
         end
      end
      wr_valid = 1'b0;
      checks++; if (readyIdx !== eLatA) begin errors++; $display("[TB] FAIL b2b_accept_idx: got %0d expected %0d", readyIdx, eLatA); end
      checks++; if (nDone !== 2) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d expected 2", nDone); end
      checks++; if (doneIdx[0] !== eLatA) begin errors++; $display("[TB] FAIL b2b_done0_idx: got %0d expected %0d", doneIdx[0], eLatA); end
      checks++; if (doneIdx[1] !== eLatA + 1 + eLatB) begin errors++; $display("[TB] FAIL b2b_done1_idx: got %0d expected %0d", doneIdx[1], eLatA + 1 + eLatB); end
      checks++; if (doneRd[0] !== eRdA) begin errors++; $display("[TB] FAIL b2b_rd0: got %b expected %b", doneRd[0], eRdA); end
      checks++; if (doneRd[1] !== eRdB) begin errors++; $display("[TB] FAIL b2b_rd1: got %b expected %b", doneRd[1], eRdB); end
   endtask

   task automatic test_random();
      logic [W-1:0] d;
      for (int n = 0; n < 12; n++) begin
         d = W'($urandom_range(0, (1 << W) - 1));
         test_write("random", d);
      end
   endtask

   // Scenarios run in order; the latch model carries state between them.
   initial begin
      test_reset();
      test_write("first", 4'b1010);
      test_write("second", 4'b0110);
      test_write("nochange", 4'b0110);
      test_stuck_bit();
      test_reset_mid_pulse();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Initiator side of the clocked SR storage element interface.
- Accepts a WIDTH-bit target value over a valid/ready handshake and computes per-bit set/reset commands.
- Sequences the gate (latch clock) pulse and reads back the latch outputs to confirm the write.
- Sits between synchronous control logic and a bank of gated SR flip-flops; guarantees s and r are never both high on any bit.

Parameters:
- WIDTH, 4, number of SR latch bits driven.
- PULSE_CYCLES, 2, cycles latch_gate is held high; legal range >=1.
- SETTLE_CYCLES, 2, cycles waited after release before readback; legal range >=2 (covers the synchronizer).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_valid  input  1  write request valid.
- wr_ready  output  1  driver idle, request can be accepted.
- wr_data  input  WIDTH  target latch value.
- s  output  WIDTH  per-bit set command to the latch bank.
- r  output  WIDTH  per-bit reset command to the latch bank.
- latch_gate  output  1  gate/clock to the latch bank.
- q_in  input  WIDTH  latch q outputs; asynchronous to clock.
- rd_data  output  WIDTH  synchronized q value captured at CHECK.
- done  output  1  one-cycle pulse when a write completes.
- err  output  1  sticky mismatch flag; cleared by next accepted write or reset.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; wr_ready=1; s=0, r=0, latch_gate=0, done=0, err=0, rd_data=0; synchronizer flops=0.
  - Latch contents are not touched.
- q_in passes through a 2-flop synchronizer; q_sync is the synchronizer output.
- Accept: on a rising edge with wr_valid&wr_ready:
  - target<=wr_data.
  - set_v<=wr_data&~q_sync.
  - rst_v<=~wr_data&q_sync.
  - err<=0.
  - wr_ready drops in the following cycle.
- By construction set_v&rst_v==0. An implementation assertion must hold (s&r)==0 on every cycle.
- States:
  - IDLE: wr_ready=1, outputs quiet. On accept: to SETUP if (set_v|rst_v)!=0, else to CHECK.
  - SETUP (1 cycle): s=set_v, r=rst_v, latch_gate=0 (data setup before gate).
  - PULSE (PULSE_CYCLES cycles): s/r held, latch_gate=1.
  - RELEASE (1 cycle): latch_gate=0, s/r still held (hold time).
  - SETTLE (SETTLE_CYCLES cycles): s=0, r=0, latch_gate=0.
  - CHECK (1 cycle): rd_data<=q_sync; done=1; err<=(q_sync!=target); next IDLE.
- Single down-counter, width clog2(max(PULSE_CYCLES,SETTLE_CYCLES))+1, loaded on entry to PULSE and to SETTLE.
- s, r, latch_gate, done are registered outputs (no combinational path from inputs).
- Latency from accept edge (edge 0) to done high:
  - 3+PULSE_CYCLES+SETTLE_CYCLES cycles for a changing write (7 at defaults).
  - 1 cycle for a no-change write.
- wr_valid while busy is ignored; the requester must hold it until wr_ready.
- Back-to-back writes: the IDLE cycle after CHECK is mandatory, so accepts are at least one IDLE cycle apart.
- Reset mid-operation: all outputs drop to 0 asynchronously, including latch_gate and s/r mid-pulse. The latch holds whatever it captured; no done is issued.
- X on q_in at power-up resolves through the synchronizer; the first write after reset treats q_sync as 0 until it settles. This is acceptable because CHECK reports any mismatch.

Decomposition:
- Package sr_latch_driver_pkg:
  - state enum (IDLE, SETUP, PULSE, RELEASE, SETTLE, CHECK).
  - Default constants DEF_WIDTH, DEF_PULSE_CYCLES, DEF_SETTLE_CYCLES.
- Sub-module sync_2ff (parameter WIDTH): two-stage synchronizer for q_in, reset to 0 by the same async reset.

Test Plan:
- Reset then write 4'b1010 against a latch model holding 4'b0000:
  - SETUP shows s=1010, r=0000.
  - latch_gate high exactly 2 cycles.
  - done at edge 7; rd_data=1010; err=0.
- Latch at 1010, write 4'b0110:
  - s=0100, r=1000.
  - (s&r)==0 every cycle; done with rd_data=0110.
- Latch at 0110, write 0110 (no change):
  - no latch_gate/s/r activity.
  - done 1 cycle after accept; err=0.
- Latch model with bit 0 stuck at 0, write 4'b0001:
  - done with rd_data=0000, err=1.
  - next write 0000 clears err to 0.
- Assert reset during PULSE:
  - latch_gate, s, r, done drop in the same cycle; wr_ready=1 after release.
  - A fresh write of 1111 then completes normally.
- Hold wr_valid high with new data while busy:
  - request is not accepted until the IDLE cycle.
  - Two writes complete in order with two done pulses.
